// File: rtl/conv5_window_reader.sv
// Raster-stream to 3x3 sliding-window reader feeding conv5 (valid windows only, stride 1).
// Optional macro CONV5_WINDOW_COORD_EN adds win_row/win_col top-left coordinate outputs.
module conv5_window_reader #(
    parameter int IMG_W  = 10,
    parameter int IMG_H  = 10,
    parameter int DATA_W = 256,
    parameter int KERNEL = 3,
    localparam int CW    = $clog2(IMG_W),
    localparam int RW    = $clog2(IMG_H)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  conv_start,
    input  logic                  in_valid,
    input  logic [DATA_W-1:0]     in_data,
    output logic                  busy,
    output logic                  window_valid,
    output logic [9*DATA_W-1:0]   window_data,
`ifdef CONV5_WINDOW_COORD_EN
    output logic [RW-1:0]         win_row,
    output logic [CW-1:0]         win_col,
`endif
    output logic                  frame_done
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1
    } state_t;

    localparam int NTAP = KERNEL * KERNEL;
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
    localparam logic [CW-1:0] COL_ONE  = CW'(1);
    localparam logic [RW-1:0] ROW_ONE  = RW'(1);
    localparam logic [CW-1:0] COL_TWO  = CW'(2);
    localparam logic [RW-1:0] ROW_TWO  = RW'(2);

    state_t                state_q, state_d;
    logic [CW-1:0]         col_q, col_d;
    logic [RW-1:0]         row_q, row_d;
    logic                  busy_q, busy_d;
    logic                  window_valid_q, window_valid_d;
    logic                  frame_done_q, frame_done_d;
    logic [9*DATA_W-1:0]   window_data_q, window_data_d;
    logic [RW-1:0]         win_row_q, win_row_d;
    logic [CW-1:0]         win_col_q, win_col_d;
    logic                  accept_s;
    logic                  emit_s;
    logic                  last_s;

    logic [DATA_W-1:0]     lb0_q [IMG_W];
    logic [DATA_W-1:0]     lb1_q [IMG_W];
    logic [DATA_W-1:0]     sh_q  [NTAP];
    logic [DATA_W-1:0]     sh_d  [NTAP];

    // Next-state, counter, window-shift and output computation.
    always_comb begin
        state_d        = state_q;
        col_d          = col_q;
        row_d          = row_q;
        window_valid_d = 1'b0;
        frame_done_d   = 1'b0;
        window_data_d  = window_data_q;
        win_row_d      = win_row_q;
        win_col_d      = win_col_q;
        accept_s       = 1'b0;
        emit_s         = 1'b0;
        last_s         = 1'b0;
        for (int k = 0; k < NTAP; k++) begin
            sh_d[k] = sh_q[k];
        end

        case (state_q)
            ST_IDLE: begin
                if (conv_start) begin
                    state_d = ST_BUSY;
                    col_d   = '0;
                    row_d   = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (in_valid) begin
                    accept_s = 1'b1;
                    last_s   = (row_q == ROW_LAST) && (col_q == COL_LAST);
                    emit_s   = (row_q >= ROW_TWO) && (col_q >= COL_TWO);
                    // Shift left one column; new right column is {row y-2, row y-1, row y}.
                    for (int r = 0; r < KERNEL; r++) begin
                        for (int c = 0; c < KERNEL - 1; c++) begin
                            sh_d[r*KERNEL+c] = sh_q[r*KERNEL+c+1];
                        end
                    end
                    sh_d[KERNEL-1]          = lb0_q[col_q];
                    sh_d[2*KERNEL-1]        = lb1_q[col_q];
                    sh_d[NTAP-1]            = in_data;
                    if (last_s) begin
                        state_d = ST_IDLE;
                        col_d   = '0;
                        row_d   = '0;
                    end else if (col_q == COL_LAST) begin
                        col_d = '0;
                        row_d = row_q + ROW_ONE;
                    end else begin
                        col_d = col_q + COL_ONE;
                    end
                    if (emit_s) begin
                        window_valid_d = 1'b1;
                        frame_done_d   = last_s;
                        win_row_d      = row_q - ROW_TWO;
                        win_col_d      = col_q - COL_TWO;
                        for (int k = 0; k < NTAP; k++) begin
                            window_data_d[k*DATA_W +: DATA_W] = sh_d[k];
                        end
                    end else begin
                        window_valid_d = 1'b0;
                    end
                end else begin
                    state_d = ST_BUSY;
                end
            end
            default: begin
                state_d = ST_IDLE;
                col_d   = '0;
                row_d   = '0;
            end
        endcase

        busy_d = (state_d == ST_BUSY);
    end

    // Control state and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= ST_IDLE;
            col_q          <= '0;
            row_q          <= '0;
            busy_q         <= 1'b0;
            window_valid_q <= 1'b0;
            frame_done_q   <= 1'b0;
            window_data_q  <= '0;
            win_row_q      <= '0;
            win_col_q      <= '0;
        end else begin
            state_q        <= state_d;
            col_q          <= col_d;
            row_q          <= row_d;
            busy_q         <= busy_d;
            window_valid_q <= window_valid_d;
            frame_done_q   <= frame_done_d;
            window_data_q  <= window_data_d;
            win_row_q      <= win_row_d;
            win_col_q      <= win_col_d;
        end
    end

    // Line buffers and window shift registers; contents are don't-care after reset.
    always_ff @(posedge clk) begin
        if (accept_s) begin
            lb0_q[col_q] <= lb1_q[col_q];
            lb1_q[col_q] <= in_data;
            for (int k = 0; k < NTAP; k++) begin
                sh_q[k] <= sh_d[k];
            end
        end
    end

    assign busy         = busy_q;
    assign window_valid = window_valid_q;
    assign window_data  = window_data_q;
    assign frame_done   = frame_done_q;
`ifdef CONV5_WINDOW_COORD_EN
    assign win_row      = win_row_q;
    assign win_col      = win_col_q;
`endif

endmodule

// File: tb/tb_conv5_window_reader.sv
// Self-checking bench for conv5_window_reader: randomized in_valid gaps against a window model.
module tb_conv5_window_reader;

    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          conv_start;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          busy;
    logic          window_valid;
    logic [9*DW-1:0] window_data;
    logic          frame_done;
`ifdef CONV5_WINDOW_COORD_EN
    logic [3:0]    win_row;
    logic [3:0]    win_col;
`endif

    int tests = 0;
    int fails = 0;
    logic [71:0] exp_hold;
    int exp_row;
    int exp_col;
    logic [71:0] got [64];
    int nw;

    conv5_window_reader #(.IMG_W(10), .IMG_H(10), .DATA_W(DW), .KERNEL(3)) dut (
        .clk(clk),
        .rst(rst),
        .conv_start(conv_start),
        .in_valid(in_valid),
        .in_data(in_data),
        .busy(busy),
        .window_valid(window_valid),
        .window_data(window_data),
`ifdef CONV5_WINDOW_COORD_EN
        .win_row(win_row),
        .win_col(win_col),
`endif
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Window whose bottom-right pixel is (y,x); slice r*3+c holds p(y-2+r, x-2+c).
    function automatic logic [71:0] exp_win(input int base, input int y, input int x);
        logic [71:0] w;
        w = '0;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                w[(r*3+c)*8 +: 8] = 8'(base + (y-2+r)*10 + (x-2+c));
        return w;
    endfunction

    task automatic run_frame(input int base, input int gap_pct, input bit start_noise,
                             input int stop_after, output int nwin);
        int x, y, n, cyc;
        bit v, emit, last;
        x = 0; y = 0; n = 0; cyc = 0; nwin = 0;
        @(negedge clk);
        conv_start = 1'b1;
        in_valid   = 1'b0;
        @(posedge clk); #1;
        chk("busy_after_start", 72'(busy), 72'(1));
        while (n < stop_after && cyc < 3000) begin
            @(negedge clk);
            v          = ($urandom_range(99) >= gap_pct);
            in_valid   = v;
            in_data    = 8'(base + y*10 + x);
            conv_start = start_noise && ($urandom_range(7) == 0);
            @(posedge clk); #1;
            cyc++;
            emit = 1'b0;
            last = 1'b0;
            if (v) begin
                emit = (y >= 2) && (x >= 2);
                last = (y == 9) && (x == 9);
                if (emit) begin
                    exp_hold = exp_win(base, y, x);
                    exp_row  = y - 2;
                    exp_col  = x - 2;
                    if (nwin < 64) got[nwin] = window_data;
                    nwin++;
                end
                x++;
                if (x == 10) begin x = 0; y++; end
                n++;
            end
            chk("window_valid", 72'(window_valid), 72'(emit));
            chk("frame_done", 72'(frame_done), 72'(last));
            chk("busy", 72'(busy), 72'(!last));
            chk("window_data", window_data, exp_hold);
`ifdef CONV5_WINDOW_COORD_EN
            chk("win_row", 72'(win_row), 72'(exp_row));
            chk("win_col", 72'(win_col), 72'(exp_col));
`endif
        end
        chk("pixels_accepted", 72'(n), 72'(stop_after));
        @(negedge clk);
        in_valid   = 1'b0;
        conv_start = 1'b0;
    endtask

    initial begin
        rst        = 1'b0;
        conv_start = 1'b0;
        in_valid   = 1'b0;
        in_data    = '0;
        exp_hold   = '0;
        exp_row    = 0;
        exp_col    = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 72'(busy), 72'(0));
        chk("rst_wv", 72'(window_valid), 72'(0));
        chk("rst_fd", 72'(frame_done), 72'(0));
        chk("rst_wd", window_data, 72'(0));
        @(negedge clk);
        rst = 1'b1;

        // in_valid beats while IDLE must be ignored.
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = 8'($urandom_range(255));
            @(posedge clk); #1;
            chk("idle_wv", 72'(window_valid), 72'(0));
            chk("idle_busy", 72'(busy), 72'(0));
        end

        // Continuous full frame.
        run_frame(0, 0, 1'b0, 100, nw);
        chk("full_count", 72'(nw), 72'(64));
        chk("first_win", got[0], {8'd22, 8'd21, 8'd20, 8'd12, 8'd11, 8'd10, 8'd2, 8'd1, 8'd0});
        chk("row_boundary_win", got[8], {8'd32, 8'd31, 8'd30, 8'd22, 8'd21, 8'd20, 8'd12, 8'd11, 8'd10});
        chk("last_win", got[63], {8'd99, 8'd98, 8'd97, 8'd89, 8'd88, 8'd87, 8'd79, 8'd78, 8'd77});
`ifdef CONV5_WINDOW_COORD_EN
        chk("last_coord", 72'({win_row, win_col}), 72'({4'd7, 4'd7}));
`endif
        @(posedge clk); #1;
        chk("post_busy", 72'(busy), 72'(0));
        chk("post_wv", 72'(window_valid), 72'(0));

        // Random gaps plus spurious conv_start while BUSY.
        run_frame(0, 50, 1'b1, 100, nw);
        chk("gap_count", 72'(nw), 72'(64));
        chk("gap_first", got[0], exp_win(0, 2, 2));
        chk("gap_last", got[63], exp_win(0, 9, 9));

        // Abandon a frame after pixel 50 with an asynchronous reset.
        run_frame(0, 0, 1'b0, 51, nw);
        #2;
        rst = 1'b0;
        #1;
        exp_hold = '0;
        exp_row  = 0;
        exp_col  = 0;
        chk("midrst_busy", 72'(busy), 72'(0));
        chk("midrst_wv", 72'(window_valid), 72'(0));
        chk("midrst_fd", 72'(frame_done), 72'(0));
        chk("midrst_wd", window_data, 72'(0));
        @(negedge clk);
        in_valid = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = 8'($urandom_range(255));
            @(posedge clk); #1;
            chk("after_rst_wv", 72'(window_valid), 72'(0));
            chk("after_rst_busy", 72'(busy), 72'(0));
        end
        @(negedge clk);
        in_valid = 1'b0;

        // Fresh frame with offset data.
        run_frame(100, 30, 1'b0, 100, nw);
        chk("fresh_count", 72'(nw), 72'(64));
        chk("fresh_first", got[0],
            {8'd122, 8'd121, 8'd120, 8'd112, 8'd111, 8'd110, 8'd102, 8'd101, 8'd100});
        chk("fresh_last", got[63], exp_win(100, 9, 9));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
